// File: rtl/bram_line_assemble.sv
// Packs byte-wide memory-bus writes into 64-bit lines for the BRAM writer.
// Optional idle auto-flush is enabled by defining BRAM_LINE_TIMEOUT_EN.
module bram_line_assemble #(
  parameter logic [7:0]  FILL_BYTE      = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_memory,
  input  logic        resetn,
  input  logic [20:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_wr,
  input  logic        mem_flush,
  output logic [17:0] addr,
  output logic [63:0] cache,
  output logic        cready,
  output logic        pending,
  output logic [15:0] line_count
);

  typedef enum logic {EMPTY, FILL} state_e;

  localparam logic [63:0] FILL_LINE = {8{FILL_BYTE}};

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e      state_q, state_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  mask_q, mask_d;
  logic [17:0] tag_q, tag_d;
  logic        flush_pending_q, flush_pending_d;
  logic [17:0] addr_q, addr_d;
  logic [63:0] cache_q, cache_d;
  logic        cready_q, cready_d;
  logic [15:0] line_count_q, line_count_d;

  logic [17:0] wr_tag;
  logic [5:0]  wr_bit;
  logic [7:0]  lane_bit;
  logic [63:0] merge_data, load_data;
  logic [7:0]  merge_mask;
  logic        flush_req, timeout_hit, emit;
  logic [17:0] emit_tag;
  logic [63:0] emit_data;

  assign wr_tag   = mem_addr[20:3];
  assign wr_bit   = {mem_addr[2:0], 3'b000};
  assign lane_bit = 8'b1 << mem_addr[2:0];

`ifdef BRAM_LINE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;

  assign timeout_hit = (state_q == FILL) && !mem_wr && (timer_q == TIMER_LAST);

  always_comb begin
    timer_d = timer_q;
    if (mem_wr || emit) begin
      timer_d = '0;
    end else if (state_q == FILL) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk_memory or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign flush_req = mem_flush | flush_pending_q | timeout_hit;

  always_comb begin
    merge_data = (state_q == EMPTY) ? FILL_LINE : data_q;
    merge_mask = ((state_q == EMPTY) ? 8'h00 : mask_q) | lane_bit;
    merge_data[wr_bit +: 8] = mem_data;
    load_data = FILL_LINE;
    load_data[wr_bit +: 8] = mem_data;

    state_d         = state_q;
    data_d          = data_q;
    mask_d          = mask_q;
    tag_d           = tag_q;
    flush_pending_d = 1'b0;
    emit            = 1'b0;
    emit_tag        = tag_q;
    emit_data       = data_q;

    if (mem_wr && (state_q == FILL) && (wr_tag != tag_q)) begin
      // Line change: retire the old line, start the new one with just this byte.
      emit            = 1'b1;
      data_d          = load_data;
      mask_d          = lane_bit;
      tag_d           = wr_tag;
      flush_pending_d = mem_flush;
    end else if (mem_wr) begin
      if ((merge_mask == 8'hFF) || flush_req) begin
        emit      = 1'b1;
        emit_tag  = wr_tag;
        emit_data = merge_data;
        data_d    = FILL_LINE;
        mask_d    = 8'h00;
        state_d   = EMPTY;
      end else begin
        data_d  = merge_data;
        mask_d  = merge_mask;
        tag_d   = wr_tag;
        state_d = FILL;
      end
    end else if ((state_q == FILL) && flush_req) begin
      emit    = 1'b1;
      data_d  = FILL_LINE;
      mask_d  = 8'h00;
      state_d = EMPTY;
    end

    addr_d       = addr_q;
    cache_d      = cache_q;
    cready_d     = emit;
    line_count_d = line_count_q;
    if (emit) begin
      addr_d       = emit_tag;
      cache_d      = emit_data;
      line_count_d = line_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_memory or negedge resetn) begin
    if (!resetn) begin
      state_q         <= EMPTY;
      data_q          <= FILL_LINE;
      mask_q          <= 8'h00;
      tag_q           <= '0;
      flush_pending_q <= 1'b0;
      addr_q          <= '0;
      cache_q         <= '0;
      cready_q        <= 1'b0;
      line_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      data_q          <= data_d;
      mask_q          <= mask_d;
      tag_q           <= tag_d;
      flush_pending_q <= flush_pending_d;
      addr_q          <= addr_d;
      cache_q         <= cache_d;
      cready_q        <= cready_d;
      line_count_q    <= line_count_d;
    end
  end

  assign addr       = addr_q;
  assign cache      = cache_q;
  assign cready     = cready_q;
  assign pending    = (state_q == FILL);
  assign line_count = line_count_q;

endmodule
